// File: rtl/alu_result_feedback_pkg.sv
// rtl/alu_result_feedback_pkg.sv - shared defaults and thread-index width helper
package alu_result_feedback_pkg;

  localparam int DEF_WORD_WIDTH      = 36;
  localparam int DEF_THREAD_COUNT    = 8;
  localparam int DEF_FEEDBACK_STAGES = 4;

  // A single-thread configuration still needs a 1-bit index port.
  function automatic int thread_idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/Delay_Line.sv
// rtl/Delay_Line.sv - fixed-depth register pipeline, one word per cycle, no stall
module Delay_Line
  import alu_result_feedback_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_WIDTH,
  parameter int DEPTH = DEF_FEEDBACK_STAGES - 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/thread_state_bank.sv
// rtl/thread_state_bank.sv - per-thread S word and sticky flags, registered read with write-first bypass
module thread_state_bank
  import alu_result_feedback_pkg::*;
#(
  parameter  int WIDTH = DEF_WORD_WIDTH,
  parameter  int COUNT = DEF_THREAD_COUNT,
  localparam int IW    = thread_idx_width(COUNT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_flag_clear,
  input  logic             i_carry,
  input  logic             i_overflow,
  input  logic [IW-1:0]    i_rd_idx,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_carry,
  output logic             o_rd_overflow
);

  logic [WIDTH-1:0] r_slot [COUNT];
  logic [COUNT-1:0] r_carry;
  logic [COUNT-1:0] r_overflow;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_carry;
  logic             r_rd_overflow;

  logic w_hit;
  logic w_carry_next;
  logic w_overflow_next;

  // Clear is applied before the OR so a same-cycle set survives the clear.
  assign w_carry_next    = (i_flag_clear ? 1'b0 : r_carry[i_wr_idx])    | i_carry;
  assign w_overflow_next = (i_flag_clear ? 1'b0 : r_overflow[i_wr_idx]) | i_overflow;
  assign w_hit           = (i_rd_idx == i_wr_idx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < COUNT; i++) begin
        r_slot[i] <= '0;
      end
      r_carry       <= '0;
      r_overflow    <= '0;
      r_rd_data     <= '0;
      r_rd_carry    <= 1'b0;
      r_rd_overflow <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_slot[i_wr_idx] <= i_wr_data;
      end
      r_carry[i_wr_idx]    <= w_carry_next;
      r_overflow[i_wr_idx] <= w_overflow_next;
      r_rd_data     <= (i_wr_en && w_hit) ? i_wr_data : r_slot[i_rd_idx];
      r_rd_carry    <= w_hit ? w_carry_next : r_carry[i_rd_idx];
      r_rd_overflow <= w_hit ? w_overflow_next : r_overflow[i_rd_idx];
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_rd_carry    = r_rd_carry;
  assign o_rd_overflow = r_rd_overflow;

endmodule

// File: rtl/alu_result_feedback.sv
// rtl/alu_result_feedback.sv - round-robin ALU result feedback: delayed R, per-thread S and sticky flags
module alu_result_feedback
  import alu_result_feedback_pkg::*;
#(
  parameter  int WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter  int THREAD_COUNT    = DEF_THREAD_COUNT,
  parameter  int FEEDBACK_STAGES = DEF_FEEDBACK_STAGES,
  localparam int TIW             = thread_idx_width(THREAD_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] Ra,
  input  logic                  carry_in,
  input  logic                  overflow_in,
  input  logic                  S_write,
  input  logic                  flag_clear,
  output logic [WORD_WIDTH-1:0] R,
  output logic                  R_zero,
  output logic                  R_negative,
  output logic [WORD_WIDTH-1:0] S,
  output logic                  carry_flag,
  output logic                  overflow_flag,
  output logic [TIW-1:0]        thread_in,
  output logic [TIW-1:0]        thread_out
);

  localparam logic [TIW-1:0] FS_MOD = TIW'(FEEDBACK_STAGES % THREAD_COUNT);

  logic [TIW-1:0]        r_thread_in;
  logic [TIW-1:0]        r_thread_out;
  logic [TIW-1:0]        w_thread_in_next;
  logic [TIW-1:0]        w_thread_out_next;
  logic [WORD_WIDTH-1:0] w_stage_pre;
  logic [WORD_WIDTH-1:0] r_R;
  logic                  r_R_zero;
  logic                  r_R_negative;

  // thread_out is derived from thread_in so the two can never drift apart.
  assign w_thread_in_next  = r_thread_in + TIW'(1);
  assign w_thread_out_next = w_thread_in_next - FS_MOD;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_thread_in  <= '0;
      r_thread_out <= '0;
    end else begin
      r_thread_in  <= w_thread_in_next;
      r_thread_out <= w_thread_out_next;
    end
  end

  Delay_Line #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FEEDBACK_STAGES - 1)
  ) u_ra_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .i_data  (Ra),
    .o_data  (w_stage_pre)
  );

  // Final stage: status bits come from the previous stage so they stay off R's output path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_R          <= '0;
      r_R_zero     <= 1'b0;
      r_R_negative <= 1'b0;
    end else begin
      r_R          <= w_stage_pre;
      r_R_zero     <= (w_stage_pre == '0);
      r_R_negative <= w_stage_pre[WORD_WIDTH-1];
    end
  end

  thread_state_bank #(
    .WIDTH (WORD_WIDTH),
    .COUNT (THREAD_COUNT)
  ) u_bank (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_wr_en       (S_write),
    .i_wr_idx      (r_thread_in),
    .i_wr_data     (Ra),
    .i_flag_clear  (flag_clear),
    .i_carry       (carry_in),
    .i_overflow    (overflow_in),
    .i_rd_idx      (w_thread_out_next),
    .o_rd_data     (S),
    .o_rd_carry    (carry_flag),
    .o_rd_overflow (overflow_flag)
  );

  assign R          = r_R;
  assign R_zero     = r_R_zero;
  assign R_negative = r_R_negative;
  assign thread_in  = r_thread_in;
  assign thread_out = r_thread_out;

endmodule
